// File: rtl/clock_repl_state_pkg.sv
// clock_repl_state_pkg: shared cache types and helpers for the replacement-state store
package clock_repl_state_pkg;
   localparam int ASSOCITIVITY = 4;
   localparam int NUM_SETS = 16;
   localparam int SET_W = $clog2(NUM_SETS);
   typedef logic [ASSOCITIVITY-1:0] way_mask_t;
   typedef logic [SET_W-1:0] set_idx_t;
   function automatic way_mask_t rotl1(input way_mask_t x);
      return {x[ASSOCITIVITY-2:0], x[ASSOCITIVITY-1]};
   endfunction
endpackage

// File: rtl/clock_repl_state_clock_replacement.sv
// clock_replacement: combinational clock-algorithm victim selector for one set
module clock_replacement #(
   parameter int WAYS = 4
) (
   input  logic [WAYS-1:0] clock_hand,
   input  logic [WAYS-1:0] use_bits,
   output logic [WAYS-1:0] evicted_block_mask,
   output logic [WAYS-1:0] clock_use_if_evict
);
   logic [2*WAYS-1:0] cand;
   logic [2*WAYS-1:0] first;
   logic [2*WAYS-1:0] sweep;
   logic all_used;
   // unrolled doubled ring: first unused way at/after the hand, and the used ways swept on the way there
   always_comb begin
      cand = {~use_bits, ~use_bits & ~(clock_hand - WAYS'(1))};
      first = cand & (~cand + (2*WAYS)'(1));
      sweep = first - {{WAYS{1'b0}}, clock_hand};
      all_used = &use_bits;
      evicted_block_mask = all_used ? clock_hand : first[WAYS-1:0] | first[2*WAYS-1:WAYS];
      clock_use_if_evict = all_used ? '0 : use_bits & ~(sweep[WAYS-1:0] | sweep[2*WAYS-1:WAYS]);
   end
endmodule

// File: rtl/clock_repl_state.sv
// clock_repl_state: per-set clock hand and use bits with registered victim selection
module clock_repl_state #(
   parameter int ASSOCITIVITY = 4,
   parameter int NUM_SETS = 16,
   localparam int SET_W = $clog2(NUM_SETS)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_hit_valid,
   input  logic [SET_W-1:0]        i_hit_set,
   input  logic [ASSOCITIVITY-1:0] i_hit_way,
   input  logic                    i_victim_valid,
   input  logic [SET_W-1:0]        i_victim_set,
   input  logic [ASSOCITIVITY-1:0] i_invalid_mask,
   output logic                    o_victim_valid,
   output logic [ASSOCITIVITY-1:0] o_victim_mask
);
   import clock_repl_state_pkg::*;
   logic [ASSOCITIVITY-1:0] hand_q [NUM_SETS];
   logic [ASSOCITIVITY-1:0] use_q [NUM_SETS];
   way_mask_t evict;
   way_mask_t clr;
   way_mask_t inv_low;
   way_mask_t victim;
   way_mask_t use_next;
   way_mask_t hand_next;
   way_mask_t hit_merge;
   logic has_inv;
   clock_replacement #(.WAYS(ASSOCITIVITY)) u_sel (
      .clock_hand         (hand_q[i_victim_set]),
      .use_bits           (use_q[i_victim_set]),
      .evicted_block_mask (evict),
      .clock_use_if_evict (clr)
   );
   // invalid ways take priority over the clock; a same-set hit is folded into the victim update
   always_comb begin
      inv_low = i_invalid_mask & (~i_invalid_mask + way_mask_t'(1));
      has_inv = |i_invalid_mask;
      victim = has_inv ? inv_low : evict;
      hit_merge = (i_hit_valid && i_hit_set == i_victim_set) ? i_hit_way : '0;
      use_next = (has_inv ? use_q[i_victim_set] | inv_low : clr | evict) | hit_merge;
      hand_next = has_inv ? hand_q[i_victim_set] : rotl1(evict);
   end
   // state commit; the victim write to a set overrides the plain hit write, which it already includes
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            hand_q[s] <= ASSOCITIVITY'(1);
            use_q[s] <= '0;
         end
         o_victim_valid <= 1'b0;
         o_victim_mask <= '0;
      end else begin
         o_victim_valid <= i_victim_valid;
         o_victim_mask <= i_victim_valid ? victim : '0;
         if (i_hit_valid) use_q[i_hit_set] <= use_q[i_hit_set] | i_hit_way;
         if (i_victim_valid) begin
            hand_q[i_victim_set] <= hand_next;
            use_q[i_victim_set] <= use_next;
         end
      end
   end
endmodule

// File: tb/tb_clock_repl_state.sv
// tb_clock_repl_state: scoreboard bench for the clock replacement-state store
module tb_clock_repl_state;
   logic clk = 1'b0;
   logic rst_n;
   logic hit_valid;
   logic [3:0] hit_set;
   logic [3:0] hit_way;
   logic victim_valid;
   logic [3:0] victim_set;
   logic [3:0] invalid_mask;
   logic o_valid;
   logic [3:0] o_mask;
   logic [3:0] m_hand [16];
   logic [3:0] m_use [16];
   logic [4:0] exp_q [$];
   int n_vec = 0;
   int n_err = 0;

   clock_repl_state dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_hit_valid    (hit_valid),
      .i_hit_set      (hit_set),
      .i_hit_way      (hit_way),
      .i_victim_valid (victim_valid),
      .i_victim_set   (victim_set),
      .i_invalid_mask (invalid_mask),
      .o_victim_valid (o_valid),
      .o_victim_mask  (o_mask)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input int s);
      check($sformatf("hand[%0d]", s), 32'(dut.hand_q[s]), 32'(m_hand[s]));
      check($sformatf("use[%0d]", s), 32'(dut.use_q[s]), 32'(m_use[s]));
   endtask

   task automatic step(input logic rn, input logic hv, input logic [3:0] hs, input logic [3:0] hw,
                       input logic vv, input logic [3:0] vs, input logic [3:0] inv);
      logic [3:0] c, u, v, nu, nh;
      logic [4:0] e;
      int h;
      rst_n = rn; hit_valid = hv; hit_set = hs; hit_way = hw;
      victim_valid = vv; victim_set = vs; invalid_mask = inv;
      v = '0;
      if (!rn) begin
         for (int s = 0; s < 16; s++) begin
            m_hand[s] = 4'b0001;
            m_use[s] = 4'b0000;
         end
         exp_q.push_back(5'b0);
      end else begin
         if (vv) begin
            c = m_hand[vs];
            u = m_use[vs];
            if (inv != 0) begin
               for (int k = 3; k >= 0; k--) if (inv[k]) v = 4'b0001 << k;
               nh = c;
               nu = u | v;
            end else begin
               h = 0;
               for (int k = 0; k < 4; k++) if (c[k]) h = k;
               nu = u;
               for (int k = 0; k < 4; k++) begin
                  if (v == 0) begin
                     if (!nu[(h + k) % 4]) v[(h + k) % 4] = 1'b1;
                     else nu[(h + k) % 4] = 1'b0;
                  end
               end
               if (v == 0) v = c;
               nu = nu | v;
               nh = {v[2:0], v[3]};
            end
            m_hand[vs] = nh;
            m_use[vs] = nu;
         end
         if (hv) m_use[hs] = m_use[hs] | hw;
         exp_q.push_back({vv, v});
      end
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("victim_valid", 32'(o_valid), 32'(e[4]));
      check("victim_mask", 32'(o_mask), 32'(e[3:0]));
   endtask

   initial begin
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      for (int s = 0; s < 16; s++) check_state(s);
      step(1, 0, 0, 0, 1, 0, 4'b0000);
      check_state(0);
      step(1, 1, 2, 4'b0001, 0, 0, 0);
      step(1, 1, 2, 4'b0010, 0, 0, 0);
      step(1, 0, 0, 0, 1, 2, 4'b0000);
      check_state(2);
      step(1, 1, 2, 4'b0011, 0, 0, 0);
      step(1, 1, 2, 4'b0100, 0, 0, 0);
      step(1, 0, 0, 0, 1, 2, 4'b0000);
      check_state(2);
      step(1, 0, 0, 0, 1, 2, 4'b0000);
      check_state(2);
      step(1, 0, 0, 0, 1, 0, 4'b1010);
      check_state(0);
      step(1, 1, 5, 4'b0100, 1, 5, 4'b0000);
      check_state(5);
      step(1, 0, 0, 0, 1, 5, 4'b0000);
      step(1, 0, 0, 0, 1, 5, 4'b0100);
      check_state(5);
      step(1, 1, 7, 4'b1000, 1, 8, 4'b0000);
      check_state(7);
      check_state(8);
      step(1, 0, 0, 0, 1, 3, 4'b0000);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 4, 4'b0001, 1, 4, 4'b0000);
      for (int s = 0; s < 16; s++) check_state(s);
      for (int i = 0; i < 400; i++)
         step(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000);
      for (int s = 0; s < 16; s++) check_state(s);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
